// File: rtl/sqrt32_sched.sv
// rtl/sqrt32_sched.sv - round-robin scheduler sharing one sqrt32 unit among N_REQ requesters
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   req, req_x        per-requester level request and 32-bit operand (requester i at [32i+31:32i])
//   ack               one-hot, one-cycle pulse marking the result for that requester
//   res_y, res_id     result and requester ID, held until the next completion
//   res_err           high with ack when the sqrt32 unit timed out
//   busy              high in every state except IDLE
//   sq_start, sq_x    start pulse and operand to the sqrt32 unit
//   sq_rdy, sq_y      ready flag and result from the sqrt32 unit
module sqrt32_sched #(
    parameter int N_REQ   = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_x,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          res_y,
    output logic [IDW-1:0]       res_id,
    output logic                 res_err,
    output logic                 busy,
    output logic                 sq_start,
    output logic [31:0]          sq_x,
    input  logic                 sq_rdy,
    input  logic [15:0]          sq_y
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_cur_id;
    logic [IDW-1:0]  r_res_id;
    logic [15:0]     r_res_y;
    logic [31:0]     r_sq_x;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            r_rdy_q;
    logic [IDW-1:0]  w_grant_id;
    logic            w_grant_vld;
    logic            w_rdy_rise;
    logic            w_timeout;

    // Search last+1, last+2, ... (mod N_REQ) so the previous winner is checked last.
    always_comb begin
        logic [IDW:0]   w_sum;
        logic [IDW-1:0] w_idx;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_last} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N_REQ)) begin
                w_sum = w_sum - (IDW+1)'(N_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_grant_vld && req[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    // A rdy level left high by the previous operation is not an edge, so it cannot complete this one.
    assign w_rdy_rise = sq_rdy & ~r_rdy_q;
    assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_rdy_rise || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last   <= IDW'(N_REQ - 1);
            r_cur_id <= '0;
            r_res_id <= '0;
            r_res_y  <= '0;
            r_sq_x   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rdy_q  <= 1'b0;
        end else begin
            r_rdy_q <= sq_rdy;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_sq_x   <= req_x[32*w_grant_id +: 32];
                        r_cur_id <= w_grant_id;
                        r_last   <= w_grant_id;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // Completion is checked first so it wins over a simultaneous timeout.
                    if (w_rdy_rise) begin
                        r_res_y  <= sq_y;
                        r_err    <= 1'b0;
                        r_res_id <= r_cur_id;
                    end else if (w_timeout) begin
                        r_res_y  <= '0;
                        r_err    <= 1'b1;
                        r_res_id <= r_cur_id;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack      = (r_state == S_DONE) ? (N_REQ'(1) << r_cur_id) : '0;
    assign res_err  = (r_state == S_DONE) & r_err;
    assign res_y    = r_res_y;
    assign res_id   = r_res_id;
    assign busy     = (r_state != S_IDLE);
    assign sq_start = (r_state == S_ISSUE);
    assign sq_x     = r_sq_x;

endmodule

// File: tb/tb_sqrt32_sched.sv
// tb/tb_sqrt32_sched.sv - self-checking bench for sqrt32_sched with a behavioural sqrt32 stub
module tb_sqrt32_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 64;
    localparam int M_NORM  = 0;
    localparam int M_HANG  = 1;
    localparam int M_STALE = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [N-1:0]      req = '0;
    logic [32*N-1:0]   req_x = '0;
    logic [N-1:0]      ack;
    logic [15:0]       res_y;
    logic [IDW-1:0]    res_id;
    logic              res_err;
    logic              busy;
    logic              sq_start;
    logic [31:0]       sq_x;
    logic              sq_rdy = 1'b0;
    logic [15:0]       sq_y = '0;

    sqrt32_sched #(.N_REQ(N), .IDW(IDW), .TIMEOUT(TO)) u_dut (
        .CLK(CLK), .RST(RST), .req(req), .req_x(req_x),
        .ack(ack), .res_y(res_y), .res_id(res_id), .res_err(res_err), .busy(busy),
        .sq_start(sq_start), .sq_x(sq_x), .sq_rdy(sq_rdy), .sq_y(sq_y)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        longint lo, hi, mid, xv;
        xv = 0;
        xv[31:0] = x;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= xv) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    // sqrt32 stub: NORM rises rdy after a random latency, HANG never does,
    // STALE keeps the old rdy high into WAIT, drops it, then rises 10 cycles later.
    int          mode = M_NORM;
    int          st = 0;
    int          lat = 5;
    logic [31:0] sx = '0;
    always @(posedge CLK) begin
        if (sq_start) begin
            sx  <= sq_x;
            st  <= 1;
            lat <= $urandom_range(3, 20);
            if (mode != M_STALE) sq_rdy <= 1'b0;
        end else if (st > 0) begin
            st <= st + 1;
            if (mode == M_NORM && st == lat) begin
                sq_rdy <= 1'b1;
                sq_y   <= ref_sqrt(sx);
                st     <= 0;
            end
            if (mode == M_STALE && st == 3) sq_rdy <= 1'b0;
            if (mode == M_STALE && st == 13) begin
                sq_rdy <= 1'b1;
                sq_y   <= ref_sqrt(sx);
                st     <= 0;
            end
            if (mode == M_HANG && st > 300) st <= 0;
        end
    end

    int cyc = 0;
    int n_start = 0;
    int start_cyc = 0;
    int ack_cyc = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (sq_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (ack != '0) ack_cyc <= cyc;
    end

    logic [31:0] xs [N];
    int m_last = N - 1;

    task automatic load_x();
        for (int i = 0; i < N; i++) req_x[32*i +: 32] = xs[i];
    endtask

    function automatic int rr_pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // Called at a negedge; returns one negedge after the ack (IDLE cycle).
    task automatic txn(input logic [N-1:0] mask, input bit keep, input bit exp_err, input string tag);
        int n;
        int id;
        logic [15:0] exp_y;
        load_x();
        req = mask;
        n = 0;
        while (ack == '0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (ack == '0) begin
            check({tag, "_ack_timeout"}, 64'd0, 64'd1);
            req = '0;
            return;
        end
        id = rr_pick(mask);
        m_last = id;
        exp_y = exp_err ? 16'd0 : ref_sqrt(xs[id]);
        check({tag, "_ack"}, 64'(ack), 64'(1) << id);
        check({tag, "_id"}, 64'(res_id), 64'(id));
        check({tag, "_y"}, 64'(res_y), 64'(exp_y));
        check({tag, "_err"}, 64'(res_err), 64'(exp_err));
        if (!keep) req = '0;
        @(negedge CLK);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        check({tag, "_ack_pulse"}, 64'(ack), 64'd0);
    endtask

    initial begin
        int s0;
        int n;
        for (int i = 0; i < N; i++) xs[i] = '0;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(sq_start), 64'd0);
        check("rst_x", 64'(sq_x), 64'd0);
        check("rst_y", 64'(res_y), 64'd0);
        check("rst_id", 64'(res_id), 64'd0);
        check("rst_err", 64'(res_err), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        xs[0] = 32'd16; xs[1] = 32'd81; xs[2] = 32'd144; xs[3] = 32'd400;
        for (int r = 0; r < 8; r++) txn(4'hF, 1'b1, 1'b0, $sformatf("rr%0d", r));
        req = '0;
        @(negedge CLK);

        xs[0] = 32'd25;
        s0 = n_start;
        txn(4'b0001, 1'b0, 1'b0, "single");
        check("single_nstart", 64'(n_start - s0), 64'd1);

        xs[0] = 32'd0;          txn(4'b0001, 1'b0, 1'b0, "x_zero");
        xs[0] = 32'hFFFF_FFFF;  txn(4'b0001, 1'b0, 1'b0, "x_max");
        check("x_max_const", 64'(res_y), 64'hFFFF);
        xs[0] = 32'd1000000;    txn(4'b0001, 1'b0, 1'b0, "x_1e6");
        check("x_1e6_const", 64'(res_y), 64'd1000);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++)
                xs[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            txn(4'($urandom_range(1, 15)), 1'b0, 1'b0, $sformatf("rnd%0d", r));
        end

        mode = M_HANG;
        xs[1] = 32'd12345;
        txn(4'b0010, 1'b0, 1'b1, "tmo");
        check("tmo_cycles", 64'(ack_cyc - start_cyc), 64'(TO + 1));
        mode = M_NORM;
        txn(4'b0010, 1'b0, 1'b0, "after_tmo");

        mode = M_STALE;
        xs[3] = 32'd49;
        txn(4'b1000, 1'b0, 1'b0, "stale");
        check("stale_cycles", 64'(ack_cyc - start_cyc), 64'd15);
        mode = M_NORM;

        mode = M_HANG;
        xs[2] = 32'd999;
        load_x();
        req = 4'b0100;
        n = 0;
        while (!sq_start && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("rstw_issue", 64'(sq_start), 64'd1);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rstw_ack", 64'(ack), 64'd0);
        check("rstw_busy", 64'(busy), 64'd0);
        check("rstw_x", 64'(sq_x), 64'd0);
        check("rstw_y", 64'(res_y), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("rstw_hold_ack", 64'(ack), 64'd0);
        end
        req = '0;
        m_last = N - 1;
        mode = M_NORM;
        RST = 1'b1;
        xs[0] = 32'd64;
        txn(4'b0101, 1'b0, 1'b0, "rstw_rr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
